id_fwd_regfile: RTL and testbench

ID_FWD_REGFILE -- requirements
Module: id_fwd_regfile

---
 rtl/id_fwd_regfile.sv | 88 ++++++++
 tb/tb_id_fwd_regfile.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/id_fwd_regfile.sv
// Decode-stage register file: 32 x 64-bit integer registers with combinational
// operand forwarding from EX/MEM1/MEM2/WB and load-use hazard detection.
module id_fwd_regfile #(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             rs1_addr,
  input  logic [4:0]             rs2_addr,
  input  logic [70:0]            ex_fwd,
  input  logic [70:0]            mem1_fwd,
  input  logic [69:0]            mem2_fwd,
  input  logic [69:0]            wb_bus,
  output logic [63:0]            rs1_data,
  output logic [63:0]            rs2_data,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic [31:0][63:0]      regs;
  logic [STALL_CNT_W-1:0] stall_cnt_reg;
  logic [64:0]            res1;
  logic [64:0]            res2;

  // x0 is hardwired; every other register is a flop so reset can clear it.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs[gi] = '0;
      end else begin : g_flop
        logic [63:0] q_reg;
        always_ff @(posedge clk) begin
          if (rst)
            q_reg <= '0;
          else if (wb_bus[69] && (wb_bus[68:64] == 5'(gi)))
            q_reg <= wb_bus[63:0];
        end
        assign regs[gi] = q_reg;
      end
    end
  endgenerate

  // Returns {hazard, value}. Only the youngest matching stage is consulted,
  // so an older load never raises a hazard once a younger producer matches.
  function automatic logic [64:0] resolve(
    input logic [4:0]  a,
    input logic [70:0] ex,
    input logic [70:0] m1,
    input logic [69:0] m2,
    input logic [69:0] wb,
    input logic [63:0] arr
  );
    logic [64:0] r;
    r = {1'b0, arr};
    if (a == 5'd0)
      r = '0;
    else if (ex[69] && (ex[68:64] == a))
      r = {ex[70], ex[63:0]};
    else if (m1[69] && (m1[68:64] == a))
      r = {m1[70], m1[63:0]};
    else if (m2[69] && (m2[68:64] == a))
      r = {1'b0, m2[63:0]};
    else if (wb[69] && (wb[68:64] == a))
      r = {1'b0, wb[63:0]};
    return r;
  endfunction

  assign res1 = resolve(rs1_addr, ex_fwd, mem1_fwd, mem2_fwd, wb_bus, regs[rs1_addr]);
  assign res2 = resolve(rs2_addr, ex_fwd, mem1_fwd, mem2_fwd, wb_bus, regs[rs2_addr]);

  assign rs1_data = rst ? 64'd0 : res1[63:0];
  assign rs2_data = rst ? 64'd0 : res2[63:0];
  assign stall    = ~rst & (res1[64] | res2[64]);

  // Saturating counter of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_reg <= '0;
    else if (stall && !(&stall_cnt_reg))
      stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_id_fwd_regfile.sv
// Self-checking bench for id_fwd_regfile: scoreboard of expected operands,
// stall and stall counts (default width and a 4-bit saturating instance).
module tb_id_fwd_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [70:0] ex_fwd, mem1_fwd;
  logic [69:0] mem2_fwd, wb_bus;
  logic [63:0] rs1_data, rs2_data, rs1_data4, rs2_data4;
  logic        stall, stall4;
  logic [31:0] stall_cnt;
  logic [3:0]  stall_cnt4;

  int total = 0;
  int bad   = 0;
  int unsigned exp_cnt  = 0;
  int unsigned exp_cnt4 = 0;

  typedef struct {
    string       tag;
    bit          chk1;
    logic [63:0] rs1;
    bit          chk2;
    logic [63:0] rs2;
    logic        stall;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  id_fwd_regfile u_dut (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .ex_fwd(ex_fwd), .mem1_fwd(mem1_fwd), .mem2_fwd(mem2_fwd), .wb_bus(wb_bus),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .stall(stall), .stall_cnt(stall_cnt)
  );

  id_fwd_regfile #(.STALL_CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .ex_fwd(ex_fwd), .mem1_fwd(mem1_fwd), .mem2_fwd(mem2_fwd), .wb_bus(wb_bus),
    .rs1_data(rs1_data4), .rs2_data(rs2_data4), .stall(stall4), .stall_cnt(stall_cnt4)
  );

  function automatic logic [70:0] fwd(bit ld, bit we, logic [4:0] a, logic [63:0] d);
    return {ld, we, a, d};
  endfunction

  function automatic logic [69:0] bus(bit we, logic [4:0] a, logic [63:0] d);
    return {we, a, d};
  endfunction

  task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ex_fwd = '0; mem1_fwd = '0; mem2_fwd = '0; wb_bus = '0;
  endtask

  // Inputs are already driven (just after negedge); sample 2ns later, then
  // advance through the posedge and update the counter model.
  task automatic step(string tag, bit c1, logic [63:0] e1, bit c2, logic [63:0] e2, logic est);
    exp_t e;
    e.tag = tag; e.chk1 = c1; e.rs1 = e1; e.chk2 = c2; e.rs2 = e2; e.stall = est;
    e.cnt = exp_cnt; e.cnt4 = 4'(exp_cnt4);
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    if (e.chk1) check_val({e.tag, ".rs1"}, rs1_data, e.rs1);
    if (e.chk2) check_val({e.tag, ".rs2"}, rs2_data, e.rs2);
    check_val({e.tag, ".stall"}, 64'(stall), 64'(e.stall));
    check_val({e.tag, ".cnt"}, 64'(stall_cnt), 64'(e.cnt));
    check_val({e.tag, ".cnt4"}, 64'(stall_cnt4), 64'(e.cnt4));
    $display("txn %s rs1=%h rs2=%h stall=%b cnt=%0d cnt4=%0d",
             e.tag, rs1_data, rs2_data, stall, stall_cnt, stall_cnt4);
    @(posedge clk);
    if (rst) begin
      exp_cnt = 0; exp_cnt4 = 0;
    end else if (est) begin
      exp_cnt++;
      if (exp_cnt4 < 15) exp_cnt4++;
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rs1_addr = 5'd3; rs2_addr = 5'd3;
    ex_fwd = fwd(1, 1, 3, 64'h77); mem1_fwd = '0; mem2_fwd = '0;
    wb_bus = bus(1, 3, 64'h55);
    @(negedge clk);
    step("rst_hold", 1, 0, 1, 0, 0);

    rst = 1'b0; idle(); rs1_addr = 5'd3; rs2_addr = 5'd31;
    step("rst_read", 1, 0, 1, 0, 0);

    wb_bus = bus(1, 5, 64'h1234); rs1_addr = 5'd5; rs2_addr = 5'd0;
    step("wb_bypass", 1, 64'h1234, 1, 0, 0);
    idle();
    step("wb_array", 1, 64'h1234, 1, 0, 0);

    wb_bus = bus(1, 0, 64'hFF); rs1_addr = 5'd0;
    step("x0_wr", 1, 0, 1, 0, 0);
    idle();
    step("x0_rd", 1, 0, 1, 0, 0);

    ex_fwd = fwd(0, 1, 5, 64'hAA); mem1_fwd = fwd(0, 1, 5, 64'hBB);
    mem2_fwd = bus(1, 5, 64'hCC); rs1_addr = 5'd5; rs2_addr = 5'd5;
    step("prio_ex", 1, 64'hAA, 1, 64'hAA, 0);
    ex_fwd = '0;
    step("prio_mem1", 1, 64'hBB, 1, 64'hBB, 0);
    mem1_fwd = '0;
    step("prio_mem2", 1, 64'hCC, 1, 64'hCC, 0);
    mem2_fwd = '0; wb_bus = bus(1, 5, 64'hDD);
    step("prio_wb", 1, 64'hDD, 1, 64'hDD, 0);
    wb_bus = bus(0, 5, 64'hEE); ex_fwd = fwd(1, 0, 5, 64'hEE);
    mem1_fwd = fwd(1, 0, 5, 64'hEE); mem2_fwd = bus(0, 5, 64'hEE);
    step("we0_ignored", 1, 64'hDD, 1, 64'hDD, 0);

    idle(); ex_fwd = fwd(1, 1, 7, 64'($urandom)); rs1_addr = 5'd7; rs2_addr = 5'd0;
    for (int i = 0; i < 3; i++) step("ld_use_ex", 0, 0, 1, 0, 1);
    idle();
    step("after_stall", 1, 0, 1, 0, 0);

    ex_fwd = fwd(0, 1, 7, 64'h11); mem1_fwd = fwd(1, 1, 7, 64'($urandom));
    step("ex_masks_ld", 1, 64'h11, 1, 0, 0);

    ex_fwd = fwd(0, 1, 8, 64'h22); mem1_fwd = fwd(1, 1, 9, 64'h99);
    rs1_addr = 5'd8; rs2_addr = 5'd9;
    step("ld_use_mem1", 1, 64'h22, 0, 0, 1);

    idle(); ex_fwd = fwd(1, 1, 9, 64'h44); mem2_fwd = bus(1, 9, 64'h33);
    rs1_addr = 5'd0;
    step("ld_not_masked", 1, 0, 0, 0, 1);

    ex_fwd = fwd(1, 1, 0, 64'hFF); mem1_fwd = fwd(1, 1, 0, 64'hFF);
    mem2_fwd = bus(1, 0, 64'hFF); wb_bus = bus(1, 0, 64'hFF);
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    step("x0_all_bus", 1, 0, 1, 0, 0);

    idle(); ex_fwd = fwd(1, 1, 4, 64'h5); rs1_addr = 5'd4;
    for (int i = 0; i < 20; i++) step("sat_run", 0, 0, 1, 0, 1);

    idle(); rst = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd5;
    step("rst_again", 1, 0, 1, 0, 0);
    rst = 1'b0;
    step("post_rst_x5", 1, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
